// File: rtl/ball_motion_if.sv
// Per-frame game signals between the frame/player sources and the ball-motion stage.
// master drives player positions and frame timing; slave returns ball position and goal pulses.
interface ball_motion_if;
    logic        frame_tick;
    logic        game_active;
    logic [9:0]  team1_ver_pos;
    logic [9:0]  team1_hor_pos;
    logic [9:0]  team2_ver_pos;
    logic [9:0]  team2_hor_pos;
    logic [18:0] ball_x;
    logic [18:0] ball_y;
    logic        goal_team1;
    logic        goal_team2;

    modport master (
        output frame_tick, game_active,
        output team1_ver_pos, team1_hor_pos, team2_ver_pos, team2_hor_pos,
        input  ball_x, ball_y, goal_team1, goal_team2
    );

    modport slave (
        input  frame_tick, game_active,
        input  team1_ver_pos, team1_hor_pos, team2_ver_pos, team2_hor_pos,
        output ball_x, ball_y, goal_team1, goal_team2
    );
endinterface

// File: rtl/ball_motion.sv
// Quaffle motion: once per frame moves the ball, bounces it off walls and players,
// then tests the six goal rings one per cycle and re-serves from centre after a score.
module ball_motion #(
    parameter int PLAYER_RADIUS = 25,
    parameter int GOAL_RADIUS   = 40,
    parameter int BALL_RADIUS   = 5,
    parameter int SERVE_VX      = 2,
    parameter int SERVE_VY      = 3,
    parameter int HOLD_FRAMES   = 60
) (
    input  logic          clk,
    input  logic          rst,
    ball_motion_if.slave  bus
);

    typedef enum logic [1:0] {S_HOLD, S_WAIT, S_PCHK, S_GCHK} state_t;
    typedef enum logic [1:0] {SC_NONE, SC_TEAM1, SC_TEAM2} scorer_t;

    localparam int HCW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

    localparam logic signed [10:0] X_MIN  = 11'(144 + BALL_RADIUS);
    localparam logic signed [10:0] X_MAX  = 11'(659 - BALL_RADIUS);
    localparam logic signed [10:0] Y_MIN  = 11'(35 + BALL_RADIUS);
    localparam logic signed [10:0] Y_MAX  = 11'(514 - BALL_RADIUS);
    localparam logic signed [10:0] CX     = 11'sd400;
    localparam logic signed [10:0] CY     = 11'sd275;
    localparam logic signed [3:0]  SVX    = 4'(SERVE_VX);
    localparam logic signed [3:0]  SVY    = 4'(SERVE_VY);
    localparam logic [21:0]        P_R2   = 22'((PLAYER_RADIUS + BALL_RADIUS) * (PLAYER_RADIUS + BALL_RADIUS));
    localparam logic [21:0]        G_R2   = 22'((GOAL_RADIUS - 2) * (GOAL_RADIUS - 2));

    state_t               state_q, state_d;
    scorer_t              scorer_q, scorer_d;
    logic [2:0]           idx_q, idx_d;
    logic [HCW-1:0]       hold_q, hold_d;
    logic signed [10:0]   x_q, x_d, y_q, y_d;
    logic signed [3:0]    vx_q, vx_d, vy_q, vy_d;
    logic                 g1_q, g1_d, g2_q, g2_d;

    logic signed [10:0]   nx, ny, px, py, gx, gy;
    logic signed [3:0]    vy_abs;
    logic                 tick, p_hit, g_hit;

    function automatic logic signed [10:0] sext4(input logic signed [3:0] v);
        return {{7{v[3]}}, v};
    endfunction

    function automatic logic signed [10:0] to_s11(input logic [9:0] p);
        return $signed({1'b0, p});
    endfunction

    function automatic logic signed [10:0] clamp(input logic signed [10:0] p,
                                                 input logic signed [10:0] lo,
                                                 input logic signed [10:0] hi);
        if (p < lo) return lo;
        if (p > hi) return hi;
        return p;
    endfunction

    // Squared Euclidean distance; |dx|,|dy| stay below 1024 so the sum fits 22 bits.
    function automatic logic [21:0] dist2(input logic signed [10:0] ax, input logic signed [10:0] ay,
                                          input logic signed [10:0] bx, input logic signed [10:0] by);
        logic signed [11:0] dx, dy;
        logic [10:0]        mx, my;
        dx = 12'(ax) - 12'(bx);
        dy = 12'(ay) - 12'(by);
        mx = dx[11] ? 11'(-dx) : 11'(dx);
        my = dy[11] ? 11'(-dy) : 11'(dy);
        return 22'(mx) * 22'(mx) + 22'(my) * 22'(my);
    endfunction

    assign tick   = bus.frame_tick & bus.game_active;
    assign nx     = x_q + sext4(vx_q);
    assign ny     = y_q + sext4(vy_q);
    assign vy_abs = vy_q[3] ? -vy_q : vy_q;

    always_comb begin
        px = 11'sd240;
        py = to_s11(bus.team1_ver_pos);
        unique case (idx_q[1:0])
            2'd0: begin px = 11'sd240;                  py = to_s11(bus.team1_ver_pos); end
            2'd1: begin px = to_s11(bus.team1_hor_pos); py = 11'sd380;                  end
            2'd2: begin px = 11'sd560;                  py = to_s11(bus.team2_ver_pos); end
            default: begin px = to_s11(bus.team2_hor_pos); py = 11'sd180;               end
        endcase
        gy = (idx_q < 3'd3) ? 11'sd100 : 11'sd450;
        case (idx_q)
            3'd0, 3'd3: gx = 11'sd300;
            3'd1, 3'd4: gx = 11'sd400;
            default:    gx = 11'sd500;
        endcase
    end

    assign p_hit = dist2(x_q, y_q, px, py) < P_R2;
    assign g_hit = dist2(x_q, y_q, gx, gy) < G_R2;

    always_comb begin
        state_d  = state_q;
        scorer_d = scorer_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        x_d      = x_q;
        y_d      = y_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        g1_d     = 1'b0;
        g2_d     = 1'b0;
        unique case (state_q)
            S_HOLD: begin
                if (tick) begin
                    if (hold_q == HCW'(HOLD_FRAMES - 1)) begin
                        hold_d  = '0;
                        vx_d    = SVX;
                        vy_d    = (scorer_q == SC_TEAM2) ? -SVY : SVY;
                        state_d = S_WAIT;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (tick) begin
                    x_d     = clamp(nx, X_MIN, X_MAX);
                    y_d     = clamp(ny, Y_MIN, Y_MAX);
                    if (nx < X_MIN || nx > X_MAX) vx_d = -vx_q;
                    if (ny < Y_MIN || ny > Y_MAX) vy_d = -vy_q;
                    idx_d   = 3'd0;
                    state_d = S_PCHK;
                end
            end
            S_PCHK: begin
                // Blue players push the ball upward, red players downward.
                if (p_hit) vy_d = (idx_q < 3'd2) ? -vy_abs : vy_abs;
                if (idx_q == 3'd3) begin
                    idx_d   = 3'd0;
                    state_d = S_GCHK;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: begin
                if (g_hit) begin
                    g1_d     = (idx_q < 3'd3);
                    g2_d     = (idx_q >= 3'd3);
                    scorer_d = (idx_q < 3'd3) ? SC_TEAM1 : SC_TEAM2;
                    x_d      = CX;
                    y_d      = CY;
                    vx_d     = '0;
                    vy_d     = '0;
                    idx_d    = 3'd0;
                    state_d  = S_HOLD;
                end else if (idx_q == 3'd5) begin
                    idx_d   = 3'd0;
                    state_d = S_WAIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_HOLD;
            scorer_q <= SC_NONE;
            idx_q    <= '0;
            hold_q   <= '0;
            x_q      <= CX;
            y_q      <= CY;
            vx_q     <= '0;
            vy_q     <= '0;
            g1_q     <= 1'b0;
            g2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            scorer_q <= scorer_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            g1_q     <= g1_d;
            g2_q     <= g2_d;
        end
    end

    assign bus.ball_x     = {8'd0, x_q};
    assign bus.ball_y     = {8'd0, y_q};
    assign bus.goal_team1 = g1_q;
    assign bus.goal_team2 = g2_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with HOLD_FRAMES=2: hold/serve, freeze, async reset,
// goal scoring, player bounces, wall clamp and player-hit priority.
module tb_ball_motion;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    ball_motion_if bif ();

    ball_motion #(.HOLD_FRAMES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x1, y1;
        int xe, ye;
        int g1, g2;
        int gcyc;
        bit moved;
    } fres_t;

    typedef struct {
        bit act;
        int ex;
        int ey;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bif.frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One frame: tick in cycle T, then watch T+1..T+12.
    task automatic do_frame(input bit act, input bit trk, output fres_t r);
        @(negedge clk);
        bif.game_active = act;
        bif.frame_tick  = 1'b1;
        @(negedge clk);
        bif.frame_tick  = 1'b0;
        r.x1 = int'(bif.ball_x);
        r.y1 = int'(bif.ball_y);
        r.g1 = 0; r.g2 = 0; r.gcyc = 0; r.moved = 1'b0;
        if (trk) begin
            bif.team1_hor_pos = bif.ball_x[9:0];
            bif.team2_hor_pos = bif.ball_x[9:0];
        end
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (bif.goal_team1) begin r.g1++; if (r.gcyc == 0) r.gcyc = k; end
            if (bif.goal_team2) begin r.g2++; if (r.gcyc == 0) r.gcyc = k; end
            if (r.gcyc == 0 && (int'(bif.ball_x) != r.x1 || int'(bif.ball_y) != r.y1))
                r.moved = 1'b1;
        end
        r.xe = int'(bif.ball_x);
        r.ye = int'(bif.ball_y);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fres_t r;
        vec_t  vecs[10];
        int    cnt, prev_x;
        bit    found;

        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bif.frame_tick    = 1'b0;
        bif.game_active   = 1'b1;
        bif.team1_ver_pos = 10'd35;
        bif.team2_ver_pos = 10'd35;
        bif.team1_hor_pos = 10'd180;
        bif.team2_hor_pos = 10'd630;

        vecs[0] = '{1'b1, 400, 275};
        vecs[1] = '{1'b1, 400, 275};
        vecs[2] = '{1'b1, 402, 278};
        vecs[3] = '{1'b0, 402, 278};
        vecs[4] = '{1'b0, 402, 278};
        vecs[5] = '{1'b0, 402, 278};
        vecs[6] = '{1'b0, 402, 278};
        vecs[7] = '{1'b0, 402, 278};
        vecs[8] = '{1'b1, 404, 281};
        vecs[9] = '{1'b1, 406, 284};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset ball_x", int'(bif.ball_x), 400);
        chk("reset ball_y", int'(bif.ball_y), 275);
        chk("reset goal1", int'(bif.goal_team1), 0);
        chk("reset goal2", int'(bif.goal_team2), 0);

        // Serve, move once, then async reset during the goal scan.
        do_frame(1'b1, 1'b0, r);
        do_frame(1'b1, 1'b0, r);
        do_frame(1'b1, 1'b0, r);
        chk("t1 first move x", r.x1, 402);
        chk("t1 first move y", r.y1, 278);
        @(negedge clk); bif.frame_tick = 1'b1;
        @(negedge clk); bif.frame_tick = 1'b0;
        chk("t1 second move x", int'(bif.ball_x), 404);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1 async rst x", int'(bif.ball_x), 400);
        chk("t1 async rst y", int'(bif.ball_y), 275);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bif.goal_team1 || bif.goal_team2) cnt++;
        end
        chk("t1 no goal after rst", cnt, 0);

        for (int i = 0; i < 10; i++) begin
            do_frame(vecs[i].act, 1'b0, r);
            chk($sformatf("vec%0d x", i), r.x1, vecs[i].ex);
            chk($sformatf("vec%0d y", i), r.y1, vecs[i].ey);
            chk($sformatf("vec%0d goals", i), r.g1 + r.g2, 0);
        end
        bif.game_active = 1'b1;

        // Score in the blue ring at (500,450) on frame 46.
        do_reset();
        do_frame(1'b1, 1'b0, r);
        do_frame(1'b1, 1'b0, r);
        cnt = 0;
        for (int f = 1; f <= 45; f++) begin
            do_frame(1'b1, 1'b0, r);
            if (r.g1 == 0 && r.g2 == 0) cnt++;
        end
        chk("t3 quiet frames", cnt, 45);
        do_frame(1'b1, 1'b0, r);
        chk("t3 f46 x", r.x1, 492);
        chk("t3 f46 y", r.y1, 413);
        chk("t3 goal2 count", r.g2, 1);
        chk("t3 goal1 count", r.g1, 0);
        chk("t3 goal cycle", r.gcyc, 11);
        chk("t3 recentre x", r.xe, 400);
        chk("t3 recentre y", r.ye, 275);
        do_frame(1'b1, 1'b0, r);
        chk("t3 hold1 x", r.x1, 400);
        do_frame(1'b1, 1'b0, r);
        chk("t3 hold2 y", r.y1, 275);
        do_frame(1'b1, 1'b0, r);
        chk("t3 reserve x", r.x1, 402);
        chk("t3 reserve y", r.y1, 272);

        // Blue horizontal player tracks the ball; then both horizontals keep it in a band
        // while it crosses the field to the left wall and back.
        do_reset();
        do_frame(1'b1, 1'b1, r);
        do_frame(1'b1, 1'b1, r);
        for (int f = 1; f <= 27; f++) begin
            do_frame(1'b1, 1'b1, r);
            if (f == 26) begin
                chk("t4 f26 x", r.x1, 452);
                chk("t4 f26 y", r.y1, 353);
            end
            if (f == 27) chk("t4 f27 y", r.y1, 350);
        end
        prev_x = r.x1;
        found = 1'b0;
        cnt = 0;
        for (int f = 0; f < 800; f++) begin
            do_frame(1'b1, 1'b1, r);
            cnt += r.g1 + r.g2;
            if (prev_x == 651 && r.x1 == 653) begin
                found = 1'b1;
                break;
            end
            prev_x = r.x1;
        end
        chk("t5 reached 653 moving right", int'(found), 1);
        chk("t5 no goals", cnt, 0);
        do_frame(1'b1, 1'b1, r);
        chk("t5 wall clamp x", r.x1, 654);
        do_frame(1'b1, 1'b1, r);
        chk("t5 after bounce x", r.x1, 652);

        // Blue horizontal and red vertical both touch the ball in frame 70.
        do_reset();
        bif.team1_hor_pos = 10'd0;
        bif.team2_hor_pos = 10'd0;
        bif.team2_ver_pos = 10'd35;
        do_frame(1'b1, 1'b0, r);
        do_frame(1'b1, 1'b0, r);
        for (int f = 1; f <= 71; f++) begin
            bif.team1_hor_pos = (f == 44) ? 10'd488 : (f == 70) ? 10'd540 : 10'd0;
            bif.team2_ver_pos = (f >= 66 && f <= 69) ? 10'd341 : (f == 70) ? 10'd353 : 10'd35;
            do_frame(1'b1, 1'b0, r);
            case (f)
                44: begin chk("t6 f44 x", r.x1, 488); chk("t6 f44 y", r.y1, 407); end
                45: chk("t6 blue bounce y", r.y1, 404);
                66: begin chk("t6 f66 x", r.x1, 532); chk("t6 f66 y", r.y1, 341); end
                67: chk("t6 red bounce y", r.y1, 344);
                70: begin
                    chk("t6 f70 y", r.y1, 353);
                    chk("t6 pchk moved", int'(r.moved), 0);
                    chk("t6 pchk goals", r.g1 + r.g2, 0);
                end
                71: begin chk("t6 red wins x", r.x1, 542); chk("t6 red wins y", r.y1, 356); end
                default: ;
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
